// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared encodings for the multicycle control FSM
package mc_defs;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_R_EXEC   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b001;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_SLTI: imm_alu_op = ALU_SLT;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// rtl/mc_mem_timer.sv - counts memory wait cycles and flags the last allowed one
module mc_mem_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // r_count is the number of waiting cycles already spent, so the current one is r_count+1
    assign o_expired = (r_count == (i_limit - 8'd1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with memory timeout trap
module multicycle_ctrl
    import mc_defs::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       fault,
    output logic [1:0] err_code
);

    localparam logic [7:0] LP_LIMIT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_fault;
    logic [1:0] r_err_code;
    logic [1:0] w_trap_cause;
    logic       w_waiting;
    logic       w_expired;

    logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_retire;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_op;

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);

    mc_mem_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_next_state != r_state),
        .i_enable  (w_waiting && !mem_ready),
        .i_limit   (LP_LIMIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_fault    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_next_state;
            // Only the transition into TRAP records a cause, so the first one sticks
            if (w_next_state == ST_TRAP && r_state != ST_TRAP) begin
                r_fault    <= 1'b1;
                r_err_code <= w_trap_cause;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_trap_cause = ERR_NONE;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 3'b000;
        w_pc_src     = 2'b00;
        w_retire     = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_op    = ALU_ADD;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:                          w_next_state = ST_R_EXEC;
                    OP_LW, OP_SW:                      w_next_state = ST_MEM_ADDR;
                    OP_BEQ:                            w_next_state = ST_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next_state = ST_I_EXEC;
                    default: begin
                        w_next_state = ST_TRAP;
                        w_trap_cause = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_R_EXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALU_R;
                w_next_state = ST_R_WB;
            end
            ST_R_WB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_alu_op     = ALU_ADD;
                w_next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next_state = ST_MEM_WB;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = ERR_TIMEOUT;
                end
            end
            ST_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_retire    = mem_ready;
                if (mem_ready) begin
                    w_next_state = ST_FETCH;
                end else if (w_expired) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = ERR_TIMEOUT;
                end
            end
            ST_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALU_SUB;
                w_pc_src     = 2'b01;
                w_pc_write   = zero;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_I_EXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_alu_op     = imm_alu_op(opcode);
                w_next_state = ST_I_WB;
            end
            ST_I_WB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: begin
                w_next_state = ST_TRAP;
            end
            default: begin
                w_next_state = ST_TRAP;
                w_trap_cause = ERR_ILLEGAL;
            end
        endcase
    end

    // Reset blanks every output so an aborted instruction cannot leak a write strobe
    assign pc_write   = w_pc_write   & ~rst;
    assign ir_write   = w_ir_write   & ~rst;
    assign i_or_d     = w_i_or_d     & ~rst;
    assign mem_read   = w_mem_read   & ~rst;
    assign mem_write  = w_mem_write  & ~rst;
    assign mem_to_reg = w_mem_to_reg & ~rst;
    assign reg_dst    = w_reg_dst    & ~rst;
    assign reg_write  = w_reg_write  & ~rst;
    assign alu_src_a  = w_alu_src_a  & ~rst;
    assign alu_src_b  = w_alu_src_b  & {2{~rst}};
    assign alu_op     = w_alu_op     & {3{~rst}};
    assign pc_src     = w_pc_src     & {2{~rst}};
    assign retire     = w_retire     & ~rst;
    assign fault      = r_fault      & ~rst;
    assign err_code   = r_err_code   & {2{~rst}};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-level check of multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO     = 6;
    localparam int CYCLES = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, retire, fault;
    logic [1:0] alu_src_b, pc_src, err_code;
    logic [2:0] alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .retire(retire), .fault(fault),
        .err_code(err_code)
    );

    typedef struct packed {
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
        logic       reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       retire, fault;
        logic [1:0] err_code;
    } ctrl_t;

    // Steps of one instruction as the bench sees them
    typedef enum int {FETCH, DECODE, REXEC, RWB, ADDR, LOAD, LOADWB, STORE, BEQ, IEXEC, IWB, TRAPPED} step_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic step_t after_decode(input logic [5:0] op);
        case (op)
            6'b000000:                                   return REXEC;
            6'b100011, 6'b101011:                        return ADDR;
            6'b000100:                                   return BEQ;
            6'b001000, 6'b001100, 6'b001101, 6'b001010:  return IEXEC;
            default:                                     return TRAPPED;
        endcase
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] op);
        case (op)
            6'b001100: return 3'b111;
            6'b001101: return 3'b101;
            6'b001010: return 3'b001;
            default:   return 3'b011;
        endcase
    endfunction

    function automatic ctrl_t expect_ctrl(input step_t s, input logic [5:0] op, input logic rdy,
                                          input logic z, input logic [1:0] err);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b011;
                           c.ir_write = rdy; c.pc_write = rdy; end
            DECODE:  begin c.alu_src_b = 2'b11; c.alu_op = 3'b011; end
            REXEC:   begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            RWB:     begin c.reg_dst = 1; c.reg_write = 1; c.retire = 1; end
            ADDR:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b011; end
            LOAD:    begin c.mem_read = 1; c.i_or_d = 1; end
            LOADWB:  begin c.reg_write = 1; c.mem_to_reg = 1; c.retire = 1; end
            STORE:   begin c.mem_write = 1; c.i_or_d = 1; c.retire = rdy; end
            BEQ:     begin c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_src = 2'b01;
                           c.pc_write = z; c.retire = 1; end
            IEXEC:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = imm_op(op); end
            IWB:     begin c.reg_write = 1; c.retire = 1; end
            TRAPPED: begin c.fault = 1; c.err_code = err; end
            default: c = '0;
        endcase
        return c;
    endfunction

    initial begin
        step_t      step;
        int         waited;
        int         mode;
        int         hold;
        logic [1:0] err;
        logic [5:0] op;
        ctrl_t      exp_c;
        ctrl_t      got_c;
        logic [5:0] legal [9];

        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                  6'b001100, 6'b001101, 6'b001010, 6'b100011};
        step = FETCH; waited = 0; mode = 0; hold = 0; err = 2'b00; op = 6'd0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc < 2)
                rst = 1'b1;
            else if (step == TRAPPED)
                rst = (hold == 0);
            else
                rst = ($urandom_range(0, 99) == 0);
            if (hold > 0) hold--;

            // New instruction: pick opcode and a memory behaviour for its waits
            if (step == FETCH && waited == 0) begin
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                else op = legal[$urandom_range(0, 8)];
                case ($urandom_range(0, 19))
                    0:               mode = 2;
                    1, 2:            mode = 3;
                    3, 4, 5, 6, 7, 8: mode = 0;
                    default:         mode = 1;
                endcase
            end
            opcode = op;
            zero   = 1'($urandom);
            if (step == FETCH || step == LOAD || step == STORE) begin
                case (mode)
                    0:       mem_ready = 1'b1;
                    2:       mem_ready = 1'b0;
                    3:       mem_ready = (waited == TO - 1);
                    default: mem_ready = 1'($urandom);
                endcase
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;

            exp_c = rst ? ctrl_t'('0) : expect_ctrl(step, op, mem_ready, zero, err);
            got_c = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_src, retire, fault, err_code};
            check_eq(rst ? "reset" : step.name(), 32'(got_c), 32'(exp_c));

            if (rst) begin
                step = FETCH; waited = 0; err = 2'b00;
            end else begin
                case (step)
                    FETCH, LOAD, STORE: begin
                        if (mem_ready) begin
                            waited = 0;
                            step = (step == FETCH) ? DECODE : (step == LOAD) ? LOADWB : FETCH;
                        end else if (waited + 1 == TO) begin
                            waited = 0; step = TRAPPED; err = 2'b10;
                            hold = $urandom_range(1, 25);
                        end else begin
                            waited++;
                        end
                    end
                    DECODE: begin
                        step = after_decode(op);
                        if (step == TRAPPED) begin
                            err = 2'b01; hold = $urandom_range(1, 25);
                        end
                    end
                    ADDR:    step = (op == 6'b100011) ? LOAD : STORE;
                    REXEC:   step = RWB;
                    IEXEC:   step = IWB;
                    TRAPPED: step = TRAPPED;
                    default: step = FETCH;
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
